// File: rtl/bcd_digit_serial_ctrl_if.sv
// Operand/result bundle for the digit-serial packed-BCD add/subtract controller.
interface bcd_digit_serial_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  sub;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_digit_serial_ctrl.sv
// Multi-digit packed-BCD adder processing one decimal digit per clock.
// Define BCD_CTRL_SUB_EN to enable ten's-complement subtraction via the sub input.
module bcd_digit_serial_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    bcd_digit_serial_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned W     = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       res_q, res_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;
`ifdef BCD_CTRL_SUB_EN
    logic               sub_q, sub_d;
`endif

    logic [3:0] a_dig, b_dig, bd, digit;
    logic [4:0] t;
    logic       carry_nx;
    logic       last;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        has_bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
        end
    endfunction

    // Single-digit BCD stage on the currently indexed digit.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
`ifdef BCD_CTRL_SUB_EN
        bd = sub_q ? (4'd9 - b_dig) : b_dig;
`else
        bd = b_dig;
`endif
        t = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry_q};
        if (t > 5'd9) begin
            digit    = 4'(t + 5'd6);
            carry_nx = 1'b1;
        end else begin
            digit    = t[3:0];
            carry_nx = 1'b0;
        end
        last = (idx_q == IDX_W'(DIGITS - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
`ifdef BCD_CTRL_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (has_bad_digit(bus.a) || has_bad_digit(bus.b)) begin
                        state_d = StDone;
                        sum_d   = '0;
                        cout_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                        a_d     = bus.a;
                        b_d     = bus.b;
                        idx_d   = '0;
                        res_d   = '0;
`ifdef BCD_CTRL_SUB_EN
                        sub_d   = bus.sub;
                        carry_d = bus.sub ? 1'b1 : bus.cin;
`else
                        carry_d = bus.cin;
`endif
                    end
                end
            end
            StRun: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (idx_q == IDX_W'(i)) res_d[4*i +: 4] = digit;
                end
                carry_d = carry_nx;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    state_d = StDone;
                    sum_d   = res_d;
                    cout_d  = carry_nx;
                    err_d   = 1'b0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BCD_CTRL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
`ifdef BCD_CTRL_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;
endmodule

// File: doc/bcd_digit_serial_ctrl.md
Name: bcd_digit_serial_ctrl

Overview:
Sequencing controller for a multi-digit packed-BCD add/subtract, computed one decimal digit per clock through a single-digit BCD add stage. It uses the same digit rule as the team's combinational single-digit BCD adder (binary add, then +6 correction when the sum exceeds 9). It accepts operands with a start/busy handshake, carries between digits internally, and reports the result with a one-cycle done pulse. It sits between a register-file/keypad front end and display logic, where area matters more than latency.

Parameters:
DIGITS, 4, number of BCD digits per operand; legal range 1..16.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new operation; sampled only in IDLE.
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
b  input  4*DIGITS  operand B, packed BCD, same packing as a.
cin  input  1  decimal carry-in for add mode.
sub  input  1  1 = a - b (only with the optional feature); otherwise ignored.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; sum, cout and err are valid from this cycle.
sum  output  4*DIGITS  result, packed BCD.
cout  output  1  add: decimal carry-out; sub: 1 = no borrow (a >= b).
err  output  1  1 = an operand digit was > 9 on the accepted operation.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: state = IDLE; busy, done, cout, err = 0; sum = 0; internal digit index, carry and operand registers = 0.
- Reset during RUN or DONE: the operation is abandoned and no done pulse is produced. After release, the block is in IDLE.
- States: IDLE, RUN, DONE.
- IDLE, start = 1, operand check:
  - Every digit of a and b is checked.
  - If any digit is > 9: go to DONE with err_next = 1, sum_next = 0, cout_next = 0.
  - Otherwise: latch a, b, carry = cin (sub mode: carry = 1), digit index = 0, and go to RUN.
- IDLE, start = 0: stay in IDLE.
- start while busy = 1: ignored, with no queuing. A start held high from IDLE is accepted only once; it is accepted again only after the block returns to IDLE.
- RUN, once per cycle for digit i:
  - bd = b_i (sub mode: bd = 9 - b_i).
  - t = a_i + bd + carry, 5-bit.
  - If t > 9: digit = (t + 6) mod 16 and carry = 1. Else: digit = t and carry = 0.
  - The digit is written into the internal result at position i, then i increments.
  - After digit DIGITS-1 is processed, go to DONE.
- RUN exit and DONE entry:
  - sum and cout load from the internal result and final carry when DONE is entered; err loads 0.
  - sum, cout and err hold their values until the next DONE entry.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Latency:
  - Valid operands: start accepted at edge N gives done = 1 in cycle N + DIGITS + 1.
  - Invalid operands: done = 1 in cycle N + 1.
- Back-to-back: start is accepted in the first IDLE cycle after DONE, so minimum issue interval is DIGITS + 2 cycles.
- Operands a, b, cin and sub are sampled only at acceptance. Later changes to these inputs have no effect on the operation in progress.
- Width rule: the index counter is clog2(DIGITS) bits, minimum 1. The final carry is not wrapped into sum; it appears only on cout.

Optional Feature:
- Macro: BCD_CTRL_SUB_EN.
- Defined: sub is sampled at acceptance. sub = 1 computes a - b by ten's complement (nines-complement of b, initial carry 1, cin ignored).
  - cout = 1: sum is a - b.
  - cout = 0: a < b, and sum is the ten's complement 10^DIGITS - (b - a).
- Undefined: sub is ignored and the block is add-only. The port remains for a stable interface.

Test Plan (DIGITS = 4):
- Basic add: a=1234, b=5678, cin=0 -> done 5 cycles after accept, sum=6912, cout=0, err=0.
- Full carry chain: a=9999, b=0001, cin=0 -> sum=0000, cout=1. Then a=0999, b=0000, cin=1 -> sum=1000, cout=0.
- Invalid digit: a=0x00A0, b=0x0001 -> done 1 cycle after accept, err=1, sum=0000, cout=0. A following valid op clears err.
- Handshake: hold start high for 10 cycles with a=0005, b=0005 -> exactly one done in that window at cycle 5, sum=0010. Change a mid-RUN -> no effect on result.
- Reset mid-op: assert rst_n low in the 3rd RUN cycle -> busy, done, sum, cout and err all 0 immediately. No done pulse. Next op 0001+0001 -> sum=0002.
- With BCD_CTRL_SUB_EN defined:
  - 0500 - 0123 -> sum=0377, cout=1.
  - 0123 - 0500 -> sum=9623, cout=0.
  - sub=1 with cin=1 -> cin has no effect.
